// File: rtl/store_buffer.sv
// Store buffer between MEM and data_memory: FIFO of pending stores, drained when the memory port is idle,
// with youngest-match store-to-load forwarding. Optional write coalescing is enabled by STORE_COALESCE_EN.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       storeValid,
  input  logic [DATA_W-1:0]          storeAddr,
  input  logic [DATA_W-1:0]          storeData,
  output logic                       storeReady,
  input  logic [DATA_W-1:0]          loadAddr,
  output logic                       loadHit,
  output logic [DATA_W-1:0]          loadData,
  input  logic                       memPortFree,
  output logic                       memWrite,
  output logic [DATA_W-1:0]          memAddress,
  output logic [DATA_W-1:0]          memWriteData,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  youngest;
  logic [CNT_W-1:0]  count_q;
  logic              full;
  logic              pop;
  logic              push;
  logic              coalesce;
  logic              unused_bits;

  assign count       = count_q;
  assign full        = (count_q == CNT_W'(DEPTH));
  assign youngest    = tail - PTR_W'(1);
  assign unused_bits = &{1'b0, loadAddr[1:0]};

  assign pop          = (count_q != '0) && memPortFree;
  assign memWrite     = pop;
  assign memAddress   = pop ? addr_q[head] : '0;
  assign memWriteData = pop ? data_q[head] : '0;

`ifdef STORE_COALESCE_EN
  logic coalescible;
  // The youngest entry cannot absorb a store if it is also the head leaving this cycle.
  assign coalescible = (count_q != '0)
                    && (addr_q[youngest][DATA_W-1:2] == storeAddr[DATA_W-1:2])
                    && !(pop && (count_q == CNT_W'(1)));
  assign storeReady  = !full || coalescible;
  assign coalesce    = storeValid && coalescible;
`else
  assign storeReady  = !full;
  assign coalesce    = 1'b0;
`endif

  assign push = storeValid && storeReady && !coalesce;

  // Walk entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    loadHit  = 1'b0;
    loadData = '0;
    idx      = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count_q) &&
          (addr_q[idx][DATA_W-1:2] == loadAddr[DATA_W-1:2])) begin
        loadHit  = 1'b1;
        loadData = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= storeAddr;
      data_q[tail] <= storeData;
    end else if (coalesce) begin
      data_q[youngest] <= storeData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic against a queue-based model.
// Honours STORE_COALESCE_EN so the same bench covers both builds.
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        storeValid;
  logic [31:0] storeAddr;
  logic [31:0] storeData;
  logic        storeReady;
  logic [31:0] loadAddr;
  logic        loadHit;
  logic [31:0] loadData;
  logic        memPortFree;
  logic        memWrite;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [2:0]  count;

  store_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .storeValid(storeValid), .storeAddr(storeAddr), .storeData(storeData),
    .storeReady(storeReady),
    .loadAddr(loadAddr), .loadHit(loadHit), .loadData(loadData),
    .memPortFree(memPortFree),
    .memWrite(memWrite), .memAddress(memAddress), .memWriteData(memWriteData),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } entry_t;
  entry_t      q[$];
  logic [31:0] drained[$];
  int          total = 0;
  int          bad   = 0;

  `ifdef STORE_COALESCE_EN
  localparam bit COALESCE = 1'b1;
  `else
  localparam bit COALESCE = 1'b0;
  `endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit same_word(input logic [31:0] a, input logic [31:0] b);
    return a[31:2] == b[31:2];
  endfunction

  // One clock: drive inputs, check combinational outputs against the model, then advance the model.
  task automatic cycle(input logic r, input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [31:0] la, input logic mpf);
    bit          e_ready, e_mw, e_hit, can_merge, do_merge, do_push;
    logic [31:0] e_ma, e_md, e_ld;
    int          n;
    reset = r; storeValid = sv; storeAddr = sa; storeData = sd; loadAddr = la; memPortFree = mpf;
    @(negedge clk);
    n = q.size();
    e_mw = (n > 0) && mpf;
    e_ma = e_mw ? q[0].addr : 32'h0;
    e_md = e_mw ? q[0].data : 32'h0;
    can_merge = COALESCE && (n > 0) && same_word(q[n-1].addr, sa) && !(e_mw && n == 1);
    e_ready = (n < DEPTH) || can_merge;
    e_hit = 1'b0; e_ld = 32'h0;
    for (int i = n - 1; i >= 0; i--)
      if (same_word(q[i].addr, la)) begin e_hit = 1'b1; e_ld = q[i].data; break; end
    chk("count", {29'h0, count}, n);
    chk("storeReady", {31'h0, storeReady}, {31'h0, e_ready});
    chk("memWrite", {31'h0, memWrite}, {31'h0, e_mw});
    chk("memAddress", memAddress, e_ma);
    chk("memWriteData", memWriteData, e_md);
    chk("loadHit", {31'h0, loadHit}, {31'h0, e_hit});
    chk("loadData", loadData, e_ld);
    if (memWrite === 1'b1) drained.push_back(memWriteData);
    @(posedge clk);
    if (r) begin
      q.delete();
    end else begin
      do_merge = sv && can_merge;
      do_push  = sv && e_ready && !do_merge;
      if (do_merge) q[n-1].data = sd;
      if (e_mw) void'(q.pop_front());
      if (do_push) q.push_back('{addr: sa, data: sd});
    end
    #1;
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    drained.delete();
  endtask

  task automatic idle(input logic [31:0] la, input logic mpf);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, la, mpf);
  endtask

  task automatic store(input logic [31:0] sa, input logic [31:0] sd, input logic mpf);
    cycle(1'b0, 1'b1, sa, sd, 32'h0, mpf);
  endtask

  initial begin
    logic [31:0] r_sa, r_la;
    reset = 1'b1; storeValid = 1'b0; storeAddr = '0; storeData = '0; loadAddr = '0; memPortFree = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    q.delete();

    // Reset state
    idle(32'h0, 1'b1);
    chk("rst_count", {29'h0, count}, 32'd0);
    chk("rst_ready", {31'h0, storeReady}, 32'd1);

    // Single store, forward, drain
    store(32'h7fffffe0, 32'h5, 1'b0);
    idle(32'h7fffffe0, 1'b0);
    chk("r031_hit", {31'h0, loadHit}, 32'd1);
    chk("r031_data", loadData, 32'h5);
    idle(32'h7fffffe0, 1'b1);
    chk("r031_cnt", {29'h0, count}, 32'd0);
    chk("r031_drain", drained.size() == 1 ? drained[0] : 32'hdead, 32'h5);

    // Fill, drop fifth, drain in order
    do_reset();
    for (int i = 0; i < 4; i++) store(32'h7fffffa0 + 4 * i, 32'h10 * (i + 1), 1'b0);
    store(32'h7fffffb0, 32'h50, 1'b0);
    chk("r032_cnt", {29'h0, count}, 32'd4);
    chk("r032_ready", {31'h0, storeReady}, 32'd0);
    for (int i = 0; i < 5; i++) idle(32'h0, 1'b1);
    chk("r032_ndrain", drained.size(), 32'd4);
    for (int i = 0; i < 4 && i < drained.size(); i++) chk("r032_order", drained[i], 32'h10 * (i + 1));

    // Youngest match wins, byte offset ignored
    do_reset();
    store(32'h7ffffff0, 32'h12, 1'b0);
    store(32'h7fffff00, 32'h55, 1'b0);
    store(32'h7ffffff0, 32'hFFFF3E79, 1'b0);
    idle(32'h7ffffff2, 1'b0);
    chk("r033_hit", {31'h0, loadHit}, 32'd1);
    chk("r033_data", loadData, 32'hFFFF3E79);

    // Steady state push+pop at count 2 with pointer wrap
    do_reset();
    store(32'h200, 32'h1000, 1'b0);
    store(32'h204, 32'h1001, 1'b0);
    for (int i = 0; i < 8; i++) store(32'h208 + 4 * i, 32'h1002 + i, 1'b1);
    chk("r034_cnt", {29'h0, count}, 32'd2);
    for (int i = 0; i < 8 && i < drained.size(); i++) chk("r034_order", drained[i], 32'h1000 + i);

    // Reset mid-drain
    do_reset();
    for (int i = 0; i < 3; i++) store(32'h300 + 4 * i, 32'h77 + i, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 32'h300, 1'b1);
    idle(32'h300, 1'b1);
    chk("r035_cnt", {29'h0, count}, 32'd0);
    chk("r035_mw", {31'h0, memWrite}, 32'd0);
    chk("r035_hit", {31'h0, loadHit}, 32'd0);

    // Back-to-back stores to one word
    do_reset();
    store(32'h7fffffe0, 32'd5, 1'b0);
    store(32'h7fffffe0, 32'd18, 1'b0);
    chk("r036_cnt", {29'h0, count}, COALESCE ? 32'd1 : 32'd2);
    for (int i = 0; i < 3; i++) idle(32'h0, 1'b1);
    if (COALESCE) begin
      chk("r036_n", drained.size(), 32'd1);
      chk("r036_d0", drained.size() > 0 ? drained[0] : 32'hdead, 32'd18);
    end else begin
      chk("r036_n", drained.size(), 32'd2);
      chk("r036_d0", drained.size() > 0 ? drained[0] : 32'hdead, 32'd5);
      chk("r036_d1", drained.size() > 1 ? drained[1] : 32'hdead, 32'd18);
    end

    // Random traffic over a small address window to provoke hits, fills and merges
    for (int i = 0; i < 400; i++) begin
      r_sa = 32'h100 + 4 * $urandom_range(0, 3) + $urandom_range(0, 3);
      r_la = 32'h100 + 4 * $urandom_range(0, 4) + $urandom_range(0, 3);
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, r_sa, $urandom, r_la,
            $urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 32, store data / address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port storeValid  input  1  MEM stage presents a store this cycle.
REQ-006 SHALL have port storeAddr  input  DATA_W  store byte address.
REQ-007 SHALL have port storeData  input  DATA_W  store word.
REQ-008 SHALL have port storeReady  output  1  buffer can accept a store this cycle.
REQ-009 SHALL have port loadAddr  input  DATA_W  address of the load in MEM this cycle.
REQ-010 SHALL have port loadHit  output  1  a buffered store matches loadAddr.
REQ-011 SHALL have port loadData  output  DATA_W  forwarded data on loadHit, else 0.
REQ-012 SHALL have port memPortFree  input  1  data_memory port unused by a load this cycle.
REQ-013 SHALL have ports memWrite (1), memAddress (DATA_W), memWriteData (DATA_W), all outputs, driving data_memory's memWrite, address and writeData inputs.
REQ-014 SHALL have port count  output  log2(DEPTH)+1  occupied entries.

Function
REQ-015 SHALL operate as a FIFO of {addr, data} entries with head/tail pointers that wrap modulo DEPTH.
REQ-016 SHALL drive storeReady = (count < DEPTH); a full buffer SHALL NOT accept a store even when a drain happens in the same cycle.
REQ-017 SHALL allocate the tail entry on the edge where storeValid && storeReady; storeValid while not ready is ignored (the pipeline stalls upstream).
REQ-018 SHALL assert memWrite combinationally when count > 0 && memPortFree, with memAddress/memWriteData = head entry; otherwise memWrite = 0 and memAddress/memWriteData = 0.
REQ-019 SHALL pop the head on every edge where memWrite = 1 (one store per cycle, single-cycle memory write).
REQ-020 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-021 SHALL compare loadAddr[DATA_W-1:2] against all valid entries combinationally; the youngest match wins.
REQ-022 SHALL treat the head being drained this cycle as still valid for forwarding; a store being pushed this cycle SHALL NOT be visible until the next cycle.
REQ-023 SHALL keep drained stores in program order; no reordering.

Reset
REQ-024 On reset, head, tail and count SHALL be 0, storeReady = 1, loadHit = 0, loadData = 0 and memWrite = 0 from the cycle after the reset edge.
REQ-025 Reset asserted mid-drain SHALL discard all pending entries; no further memWrite until new stores arrive.
REQ-026 Reset SHALL take priority over simultaneous push and pop on the same edge.

Configuration
REQ-027 Macro STORE_COALESCE_EN SHALL control write coalescing.
REQ-028 With STORE_COALESCE_EN defined, a store whose word address equals the youngest valid entry SHALL overwrite that entry's data without allocating, unless that entry is the head being popped this cycle.
REQ-029 Coalescing SHALL be permitted when full, so storeReady = 1 when full and the incoming address matches a coalescible youngest entry.
REQ-030 Without STORE_COALESCE_EN, every accepted store SHALL allocate a new entry and REQ-016 applies unmodified.

Verification
REQ-031 Store 0x00000005 @ 0x7fffffe0, memPortFree = 0 -> count = 1, loadAddr 0x7fffffe0 gives loadHit = 1 and loadData = 5; memPortFree = 1 -> one cycle of memWrite = 1 at 0x7fffffe0, then count = 0.
REQ-032 With memPortFree = 0, fill DEPTH = 4 stores (0x10, 0x20, 0x30, 0x40 @ 0x7fffffa0+4i) -> storeReady = 0, count = 4, and a fifth store is dropped; then drain -> memWrite sequence in the same order over 4 cycles.
REQ-033 Stores 0x12 then 0xFFFF3E79 (-49543) to 0x7ffffff0, with an intervening store to another address, drain blocked -> load 0x7ffffff2 returns loadData = 0xFFFF3E79 (youngest wins, byte offset ignored).
REQ-034 At count = 2, push and pop in the same cycle -> count stays 2 and head/tail wrap correctly across 8 such cycles.
REQ-035 Reset with 3 entries pending during memWrite -> next cycle count = 0, memWrite = 0, loadHit = 0.
REQ-036 STORE_COALESCE_EN defined: two back-to-back stores (5, then 18) @ 0x7fffffe0, drain blocked -> count = 1 and drained data = 18; undefined -> count = 2 and writes of 5 then 18.
